// File: rtl/hsfsm_pkg.sv
// Shared definitions for the hierarchical-state-machine transition logger:
// substate codes, master state encoding and the packed transition record.
package hsfsm_pkg;

    localparam logic [1:0] SUB_IDLE     = 2'b00;
    localparam logic [1:0] SUB_THINKING = 2'b01;
    localparam logic [1:0] SUB_RUNNING  = 2'b10;
    localparam logic [1:0] SUB_ILLEGAL  = 2'b11;

    typedef enum logic {
        MST_UNPRIMED = 1'b0,
        MST_PRIMED   = 1'b1
    } hsfsm_mst_e;

    localparam int XREC_TS_W    = 8;
    localparam int XREC_DWELL_W = 8;

    typedef struct packed {
        logic                    chg1;
        logic                    chg2;
        logic [1:0]              s1_old;
        logic [1:0]              s1_new;
        logic [1:0]              s2_old;
        logic [1:0]              s2_new;
        logic [XREC_TS_W-1:0]    timestamp;
        logic [XREC_DWELL_W-1:0] dwell;
    } hsfsm_xrec_t;

    function automatic logic is_illegal(input logic [1:0] code);
        return code == SUB_ILLEGAL;
    endfunction

endpackage

// File: rtl/hsfsm_fwft_fifo.sv
// First-word-fall-through FIFO: the head entry is always visible on rdata_o.
// A push while full is accepted only if a pop frees the head slot in the same cycle.
module hsfsm_fwft_fifo #(
    parameter  int DEPTH  = 8,
    parameter  int WIDTH  = 26,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int FILL_W = PTR_W + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic              pop_i,
    output logic [WIDTH-1:0]  rdata_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [FILL_W-1:0] fill_o
);

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [FILL_W-1:0] fill_q;
    logic              do_push;
    logic              do_pop;

    assign full_o  = (fill_q == FILL_W'(DEPTH));
    assign empty_o = (fill_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rd_ptr_q];
    assign fill_o  = fill_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   fill_q <= fill_q + FILL_W'(1);
                2'b01:   fill_q <= fill_q - FILL_W'(1);
                default: fill_q <= fill_q;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; occupancy is tracked by
    // fill_q, so stale contents are never observable and the array maps to RAM.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/hsfsm_transition_logger.sv
// Detects substate changes on two channels and queues timestamped transition
// records with dwell time; tracks overflow drops and illegal substate codes.
module hsfsm_transition_logger
    import hsfsm_pkg::*;
#(
    parameter  int DEPTH   = 8,
    parameter  int TS_W    = 8,
    parameter  int DWELL_W = 8,
    localparam int REC_W   = 2 + 8 + TS_W + DWELL_W,
    localparam int FILL_W  = $clog2(DEPTH) + 1
) (
    input  logic              sysclk,
    input  logic              sysrst,
    input  logic [1:0]        sus1_i,
    input  logic [1:0]        sus2_i,
    input  logic [TS_W-1:0]   event_ctr_i,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [REC_W-1:0]  rd_data,
    output logic [FILL_W-1:0] fill,
    output logic [7:0]        drop_cnt,
    output logic              overflow,
    output logic              illegal
);

    localparam logic [DWELL_W-1:0] DWELL_MAX = '1;

    hsfsm_mst_e         state_q, state_d;
    logic [1:0]         s1_q, s1_d;
    logic [1:0]         s2_q, s2_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [7:0]         drop_q, drop_d;
    logic               ovf_q, ovf_d;
    logic               ill_q, ill_d;

    logic               chg1;
    logic               chg2;
    logic               push;
    logic [REC_W-1:0]   rec;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;

    assign rd_valid = !fifo_empty;
    assign pop      = rd_valid && rd_ready;

    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        dwell_d = dwell_q;
        drop_d  = drop_q;
        ovf_d   = ovf_q;
        ill_d   = ill_q;
        chg1    = 1'b0;
        chg2    = 1'b0;
        push    = 1'b0;
        rec     = '0;

        case (state_q)
            MST_UNPRIMED: begin
                state_d = MST_PRIMED;
                s1_d    = sus1_i;
                s2_d    = sus2_i;
                dwell_d = '0;
            end
            MST_PRIMED: begin
                chg1 = (sus1_i != s1_q);
                chg2 = (sus2_i != s2_q);
                rec  = {chg1, chg2, s1_q, sus1_i, s2_q, sus2_i, event_ctr_i, dwell_q};
                if (chg1 || chg2) begin
                    push    = 1'b1;
                    dwell_d = '0;
                    // A full FIFO still takes the record when the head leaves this cycle.
                    if (fifo_full && !pop) begin
                        if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
                        ovf_d = 1'b1;
                    end
                end else if (dwell_q != DWELL_MAX) begin
                    dwell_d = dwell_q + DWELL_W'(1);
                end
                if (is_illegal(sus1_i) || is_illegal(sus2_i)) ill_d = 1'b1;
                s1_d = sus1_i;
                s2_d = sus2_i;
            end
            default: state_d = MST_UNPRIMED;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (sysrst) begin
            state_q <= MST_UNPRIMED;
            s1_q    <= SUB_IDLE;
            s2_q    <= SUB_IDLE;
            dwell_q <= '0;
            drop_q  <= '0;
            ovf_q   <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            dwell_q <= dwell_d;
            drop_q  <= drop_d;
            ovf_q   <= ovf_d;
            ill_q   <= ill_d;
        end
    end

    hsfsm_fwft_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .clk_i   (sysclk),
        .rst_i   (sysrst),
        .push_i  (push),
        .wdata_i (rec),
        .pop_i   (rd_ready),
        .rdata_o (rd_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .fill_o  (fill)
    );

    assign drop_cnt = drop_q;
    assign overflow = ovf_q;
    assign illegal  = ill_q;

endmodule

// File: tb/tb_hsfsm_transition_logger.sv
// Self-checking bench for hsfsm_transition_logger: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_hsfsm_transition_logger;
    import hsfsm_pkg::*;

    localparam int DEPTH = 8;

    logic        sysclk = 1'b0;
    logic        sysrst;
    logic [1:0]  sus1_i;
    logic [1:0]  sus2_i;
    logic [7:0]  event_ctr_i;
    logic        rd_ready;
    logic        rd_valid;
    logic [25:0] rd_data;
    logic [3:0]  fill;
    logic [7:0]  drop_cnt;
    logic        overflow;
    logic        illegal;

    hsfsm_transition_logger #(.DEPTH(DEPTH), .TS_W(8), .DWELL_W(8)) dut (
        .sysclk      (sysclk),
        .sysrst      (sysrst),
        .sus1_i      (sus1_i),
        .sus2_i      (sus2_i),
        .event_ctr_i (event_ctr_i),
        .rd_ready    (rd_ready),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .fill        (fill),
        .drop_cnt    (drop_cnt),
        .overflow    (overflow),
        .illegal     (illegal)
    );

    always #5 sysclk = ~sysclk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: a queue of expected records plus the logger's observable state.
    hsfsm_xrec_t mq[$];
    bit          m_primed;
    logic [1:0]  m_s1, m_s2;
    int          m_dwell;
    int          m_drop;
    bit          m_ovf;
    bit          m_ill;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_update(input bit rst, input logic [1:0] a, input logic [1:0] b,
                                input logic [7:0] ts, input bit rdy);
        hsfsm_xrec_t r;
        bit c1, c2;
        if (rst) begin
            mq.delete();
            m_primed = 0; m_s1 = 2'b00; m_s2 = 2'b00;
            m_dwell = 0; m_drop = 0; m_ovf = 0; m_ill = 0;
        end else if (!m_primed) begin
            m_primed = 1; m_s1 = a; m_s2 = b; m_dwell = 0;
        end else begin
            c1 = (a != m_s1);
            c2 = (b != m_s2);
            if (a == 2'b11 || b == 2'b11) m_ill = 1;
            if (rdy && mq.size() > 0) void'(mq.pop_front());
            if (c1 || c2) begin
                r.chg1 = c1; r.chg2 = c2;
                r.s1_old = m_s1; r.s1_new = a;
                r.s2_old = m_s2; r.s2_new = b;
                r.timestamp = ts; r.dwell = 8'(m_dwell);
                if (mq.size() < DEPTH) mq.push_back(r);
                else begin
                    if (m_drop < 255) m_drop++;
                    m_ovf = 1;
                end
                m_dwell = 0;
            end else if (m_dwell < 255) begin
                m_dwell++;
            end
            m_s1 = a; m_s2 = b;
        end
    endtask

    task automatic check_all();
        chk("rd_valid", 32'(rd_valid), 32'(mq.size() != 0));
        chk("fill", 32'(fill), 32'(mq.size()));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("illegal", 32'(illegal), 32'(m_ill));
        if (mq.size() != 0) chk("rd_data", 32'(rd_data), 32'(mq[0]));
    endtask

    // Drive inputs, take one rising edge, advance the model, then sample 1 ns later.
    task automatic step(input bit rst, input logic [1:0] a, input logic [1:0] b,
                        input logic [7:0] ts, input bit rdy);
        sysrst = rst; sus1_i = a; sus2_i = b; event_ctr_i = ts; rd_ready = rdy;
        @(posedge sysclk);
        model_update(rst, a, b, ts, rdy);
        #1;
        check_all();
    endtask

    initial begin
        hsfsm_xrec_t exp_rec;
        hsfsm_xrec_t got;
        logic [1:0]  ra, rb;
        logic [3:0]  fill_before;

        // Reset, then a steady input: no record ever, including on the priming edge.
        step(1, 2'b00, 2'b10, 8'h00, 0);
        step(1, 2'b00, 2'b10, 8'h00, 0);
        for (int i = 0; i < 20; i++) step(0, 2'b00, 2'b10, 8'(i), 0);
        chk("quiet_valid", 32'(rd_valid), 32'd0);
        chk("quiet_fill", 32'(fill), 32'd0);

        // Prime, 15 quiet cycles, then sus1 00->10 with timestamp 0x2F.
        step(1, 2'b00, 2'b10, 8'h00, 0);
        step(0, 2'b00, 2'b10, 8'h00, 0);
        for (int i = 0; i < 15; i++) step(0, 2'b00, 2'b10, 8'(i), 0);
        step(0, 2'b10, 2'b10, 8'h2F, 0);
        exp_rec.chg1 = 1'b1; exp_rec.chg2 = 1'b0;
        exp_rec.s1_old = 2'b00; exp_rec.s1_new = 2'b10;
        exp_rec.s2_old = 2'b10; exp_rec.s2_new = 2'b10;
        exp_rec.timestamp = 8'h2F; exp_rec.dwell = 8'd15;
        chk("first_valid", 32'(rd_valid), 32'd1);
        chk("first_rec", 32'(rd_data), 32'(exp_rec));

        // Both channels changing on one edge yield a single combined record.
        step(0, 2'b10, 2'b00, 8'h30, 0);
        fill_before = fill;
        step(0, 2'b00, 2'b10, 8'h31, 0);
        chk("both_fill_inc", 32'(fill), 32'(fill_before) + 1);
        step(0, 2'b00, 2'b10, 8'h32, 1);
        step(0, 2'b00, 2'b10, 8'h33, 1);
        got = rd_data;
        chk("both_chg_bits", 32'({got.chg1, got.chg2}), 32'd3);
        chk("both_one_left", 32'(fill), 32'd1);
        step(0, 2'b00, 2'b10, 8'h34, 1);
        chk("both_drained", 32'(fill), 32'd0);

        // Overflow: ten changes into an empty 8-deep FIFO with no reader.
        step(1, 2'b00, 2'b00, 8'h00, 0);
        step(0, 2'b00, 2'b00, 8'h00, 0);
        for (int i = 0; i < 10; i++) step(0, (i % 2 == 0) ? 2'b01 : 2'b00, 2'b00, 8'(8'h40 + i), 0);
        got = rd_data;
        chk("ovf_fill", 32'(fill), 32'd8);
        chk("ovf_drop", 32'(drop_cnt), 32'd2);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_head_ts", 32'(got.timestamp), 32'h40);
        step(0, 2'b01, 2'b00, 8'h4A, 1);
        chk("full_pop_fill", 32'(fill), 32'd8);
        chk("full_pop_drop", 32'(drop_cnt), 32'd2);

        // Illegal code on sus2 for a single cycle.
        step(1, 2'b00, 2'b00, 8'h00, 0);
        step(0, 2'b00, 2'b00, 8'h00, 0);
        step(0, 2'b00, 2'b11, 8'h55, 0);
        got = rd_data;
        chk("ill_set", 32'(illegal), 32'd1);
        chk("ill_rec_s2new", 32'(got.s2_new), 32'd3);
        step(0, 2'b00, 2'b00, 8'h56, 0);
        chk("ill_sticky", 32'(illegal), 32'd1);
        step(1, 2'b00, 2'b00, 8'h00, 0);
        chk("ill_cleared", 32'(illegal), 32'd0);

        // Reset while five records are held and the reader is active.
        step(0, 2'b00, 2'b00, 8'h00, 0);
        for (int i = 0; i < 5; i++) step(0, (i % 2 == 0) ? 2'b10 : 2'b00, 2'b00, 8'(i), 0);
        chk("five_fill", 32'(fill), 32'd5);
        step(1, 2'b01, 2'b01, 8'h00, 1);
        chk("rst_fill", 32'(fill), 32'd0);
        chk("rst_valid", 32'(rd_valid), 32'd0);
        step(0, 2'b10, 2'b01, 8'h00, 0);
        chk("reprime_fill", 32'(fill), 32'd0);

        // Dwell saturation after a long quiet stretch.
        for (int i = 0; i < 260; i++) step(0, 2'b10, 2'b01, 8'(i), 0);
        step(0, 2'b01, 2'b01, 8'h77, 0);
        got = rd_data;
        chk("dwell_sat", 32'(got.dwell), 32'hFF);

        // drop_cnt saturation: far more changes than the FIFO can hold.
        step(1, 2'b00, 2'b00, 8'h00, 0);
        step(0, 2'b00, 2'b00, 8'h00, 0);
        for (int i = 0; i < 270; i++) step(0, (i % 2 == 0) ? 2'b01 : 2'b00, 2'b00, 8'(i), 0);
        chk("drop_sat", 32'(drop_cnt), 32'd255);

        // Randomized traffic with occasional resets and illegal codes.
        ra = 2'b00; rb = 2'b00;
        step(1, ra, rb, 8'h00, 0);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 1) == 0) ra = ($urandom_range(0, 11) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            if ($urandom_range(0, 1) == 0) rb = ($urandom_range(0, 11) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            step($urandom_range(0, 79) == 0, ra, rb, 8'($urandom), $urandom_range(0, 2) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/hsfsm_transition_logger.md
Name: hsfsm_transition_logger

Overview:
- Downstream consumer of the hierarchical-state-machine stage.
- Watches the two 2-bit substate buses (sus1, sus2) plus the 8-bit event counter, and detects every substate change.
- Pushes a timestamped transition record into a small first-word-fall-through FIFO, drained by a valid/ready reader (debug/UART bridge).
- Also flags illegal substate codes and counts records dropped on overflow.

Parameters:
- DEPTH, 8, FIFO entries (power of two, >=2)
- TS_W, 8, width of event_ctr_i / timestamp field
- DWELL_W, 8, width of saturating dwell counter

Ports:
- sysclk  in  1  system clock, all logic on rising edge
- sysrst  in  1  synchronous active-high reset
- sus1_i  in  2  substate 1 code (00 idle, 01 thinking, 10 running, 11 illegal)
- sus2_i  in  2  substate 2 code, same encoding
- event_ctr_i  in  TS_W  upstream free-running event counter
- rd_ready  in  1  reader accepts head record this cycle
- rd_valid  out  1  FIFO non-empty
- rd_data  out  2+8+TS_W+DWELL_W  head record: {chg1, chg2, s1_old, s1_new, s2_old, s2_new, timestamp, dwell}
- fill  out  $clog2(DEPTH)+1  current occupancy
- drop_cnt  out  8  records lost to overflow, saturates at 255
- overflow  out  1  sticky, set on first drop
- illegal  out  1  sticky, set when either input equals 2'b11

Behaviour:
- Reset (sysrst=1 at an edge):
  - FIFO empty: rd_valid=0, fill=0.
  - drop_cnt=0, overflow=0, illegal=0, dwell=0.
  - s1_q/s2_q=00, primed=0.
  - Reset wins over every simultaneous event; records held mid-drain are discarded.
- Priming: the first edge after reset loads s1_q<=sus1_i, s2_q<=sus2_i, sets primed=1, and logs nothing.
- Each primed edge:
  - chg1=(sus1_i!=s1_q), chg2=(sus2_i!=s2_q).
  - If chg1|chg2, write record {chg1, chg2, s1_q, sus1_i, s2_q, sus2_i, event_ctr_i, dwell}.
  - Then s*_q<=sus*_i.
- Simultaneous change on both channels produces ONE combined record with both chg bits set.
- Latency: an input change present before edge k is visible at rd_data with rd_valid=1 immediately after edge k (FWFT, rd_data driven from the head slot).
- Dwell:
  - Counts primed cycles since the last detected change (logged or dropped), saturating at 2^DWELL_W-1.
  - Cleared to 0 on the edge a change is detected.
  - The record carries the pre-clear value.
- Read: a pop occurs at an edge with rd_valid&rd_ready. rd_ready while empty is ignored.
- Full (fill==DEPTH):
  - Detected change with no pop in the same cycle: record dropped, drop_cnt+1 (saturating), overflow<=1.
  - Pop and change in the same cycle: the write is accepted, fill unchanged, no drop.
- Push and pop in the same cycle (not full/empty edge cases): fill unchanged.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. fill is tracked separately, not derived from the pointers.
- Illegal: sus1_i==11 or sus2_i==11 on any primed edge sets illegal<=1 (sticky until reset). The transition is still logged normally.
- No state machine beyond two states: UNPRIMED -> PRIMED, and back to UNPRIMED only via sysrst.

Decomposition:
- Shared package hsfsm_pkg holds:
  - the substate code constants (SUB_IDLE=00, SUB_THINKING=01, SUB_RUNNING=10, SUB_ILLEGAL=11);
  - the master state constants;
  - a packed record typedef hsfsm_xrec_t with the field order above.
- One natural sub-module: hsfsm_fwft_fifo, parameterised by DEPTH and width, with push/pop/full/empty/fill and synchronous reset. The logger wraps it with the detect/dwell/drop logic.

Test Plan:
- Reset then hold sus1=00, sus2=10 for 20 cycles -> rd_valid stays 0, fill=0, no spurious record on the priming edge.
- After priming:
  - Stimulus: sus1 00->10 at an edge with event_ctr_i=0x2F after 15 quiet cycles; rd_ready=0.
  - Response: next cycle rd_valid=1, record chg1=1, chg2=0, s1 00->10, s2 10->10, ts=0x2F, dwell=15.
- Both channels change at the same edge (sus1 10->00, sus2 00->10) -> exactly one record with chg1=chg2=1; fill increments by 1.
- Overflow path:
  - Stimulus: 10 changes with rd_ready=0 and DEPTH=8.
  - Response: fill=8, drop_cnt=2, overflow=1; the head is still the first record.
  - Then a change with rd_ready=1 at full -> write accepted, fill stays 8, drop_cnt stays 2.
- Drive sus2=11 for one cycle -> illegal=1 and stays 1; the transition record is logged with s2_new=11; sysrst clears illegal, drop_cnt, and the FIFO.
- Sysrst asserted while fill=5 and rd_ready=1 -> next cycle fill=0, rd_valid=0; the following edge primes without logging.
